// File: rtl/sumaproductos_pkg.sv
// Purpose : shared FSM encoding, default stimulus width and the all-agree test for the sweep.
// Latency : n/a (types, constants and a combinational function only).
// Backpr. : n/a.
package sumaproductos_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } estado_t;

  // The four implementations agree only when their responses are all 0 or all 1.
  function automatic logic todos_iguales(input logic [3:0] rta);
    return (rta == 4'b0000) || (rta == 4'b1111);
  endfunction

endpackage

// File: rtl/barrido_settle_cnt.sv
// Purpose : SETTLE-cycle hold timer; load arms it, expira rises in the last hold cycle.
// Latency : expira is high on the SETTLE-th enabled cycle after load (combinational from the count).
// Backpr. : none; dec simply stops the count while low.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   carga      : reload to SETTLE-1 (has priority over dec)
//   dec        : count down while non-zero
//   expira     : count has reached zero
module barrido_settle_cnt #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic carga,
  input  logic dec,
  output logic expira
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // Loading SETTLE-1 and expiring at zero yields exactly SETTLE enabled cycles.
  localparam logic [CW-1:0] RECARGA = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (carga) begin
      cnt <= RECARGA;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expira = (cnt == '0);

endmodule

// File: rtl/sumaproductos_barrido.sv
// Purpose : sweeps every WIDTH-bit vector into four sum-of-products implementations and checks they agree.
// Latency : 2^WIDTH*(SETTLE+1) cycles of sweep plus one DONE cycle; results final in the DONE cycle.
// Backpr. : none; start is only sampled in IDLE and ignored while a sweep runs.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (aborts a sweep, no done)
//   start        : begin a sweep (IDLE only)
//   estimulo     : vector driven to all implementations
//   rta          : {comportamental, funcional, estructural, primitiva} responses
//   busy, done   : sweep running / one-cycle end pulse
//   pass         : last sweep had zero failing vectors
//   errores      : failing vector count of the last sweep
//   primer_fallo : first failing vector, valid when fallo_valido=1
module sumaproductos_barrido
  import sumaproductos_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] estimulo,
  input  logic [3:0]       rta,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   errores,
  output logic [WIDTH-1:0] primer_fallo,
  output logic             fallo_valido
);

  localparam logic [WIDTH-1:0] ULTIMO = {WIDTH{1'b1}};

  estado_t        estado;
  logic           carga;
  logic           expira;
  logic           falla;
  logic           ultimo;
  logic [WIDTH:0] errores_nxt;

  assign ultimo      = (estimulo == ULTIMO);
  assign falla       = !todos_iguales(rta);
  assign errores_nxt = errores + {{WIDTH{1'b0}}, falla};

  // The hold timer is armed on every edge that enters APPLY.
  assign carga = ((estado == IDLE) && start) || ((estado == SAMPLE) && !ultimo);

  barrido_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .carga  (carga),
    .dec    (estado == APPLY),
    .expira (expira)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= IDLE;
      estimulo     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      errores      <= '0;
      primer_fallo <= '0;
      fallo_valido <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (start) begin
            estado       <= APPLY;
            estimulo     <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            errores      <= '0;
            primer_fallo <= '0;
            fallo_valido <= 1'b0;
          end
        end

        APPLY: begin
          if (expira) begin
            estado <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (falla) begin
            errores <= errores_nxt;
            if (!fallo_valido) begin
              primer_fallo <= estimulo;
              fallo_valido <= 1'b1;
            end
          end
          if (ultimo) begin
            // Verdict uses the count including this last vector so it is final during DONE.
            estado <= DONE;
            done   <= 1'b1;
            pass   <= (errores_nxt == '0);
          end else begin
            estado   <= APPLY;
            estimulo <= estimulo + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end

        DONE: begin
          estado <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
        end

        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule
